// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter owner and fetch sequencer (run / single-step /
//               halted) with IF/ID flush generation and fetch-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int               NB_PC    = 32,
    parameter logic [NB_PC-1:0] RESET_PC = '0,
    parameter int               NB_CNT   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_step_mode,
    input  logic              i_step,
    input  logic              i_pc_mux_ctrl,
    input  logic [NB_PC-1:0]  i_target_addr,
    input  logic              i_stall,
    input  logic              i_halt_fetched,
    output logic [NB_PC-1:0]  o_pc,
    output logic [NB_PC-1:0]  o_pc_plus4,
    output logic              o_fetch_en,
    output logic              o_flush_ifid,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_cnt
);

    localparam logic [NB_PC-1:0]  c_pc_step  = NB_PC'(4);
    localparam logic [NB_CNT-1:0] c_cnt_step = NB_CNT'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_PC-1:0]   r_pc;
    logic [NB_PC-1:0]   w_pc_next;
    logic [NB_CNT-1:0]  r_cycle_cnt;
    logic               w_fetch_en;
    logic               w_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_cycle_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_fetch_en) begin
                r_cycle_cnt <= r_cycle_cnt + c_cnt_step;
            end
        end
    end

    // A fetched HALT suppresses the PC update and any redirect flush.
    always_comb begin
        w_state_next = r_state;
        w_fetch_en   = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = i_step_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                w_fetch_en = ~i_stall & ~i_halt_fetched & ~i_rst;
                if (i_halt_fetched) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_STEP_WAIT: begin
                if (i_step) begin
                    w_state_next = ST_STEP_EXEC;
                end
            end
            ST_STEP_EXEC: begin
                w_fetch_en   = ~i_stall & ~i_halt_fetched & ~i_rst;
                w_state_next = i_halt_fetched ? ST_HALTED : ST_STEP_WAIT;
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_flush = w_fetch_en & i_pc_mux_ctrl;
    end

    always_comb begin
        w_pc_next = r_pc;
        if (w_fetch_en) begin
            w_pc_next = i_pc_mux_ctrl ? i_target_addr : (r_pc + c_pc_step);
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_plus4   = r_pc + c_pc_step;
    assign o_fetch_en   = w_fetch_en;
    assign o_flush_ifid = w_flush;
    assign o_halted     = (r_state == ST_HALTED);
    assign o_cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Scoreboard bench for pc_fetch_unit (32-bit and 8-bit PC builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        pc_mux;
    logic [31:0] target;
    logic        stall;
    logic        halt_f;

    logic [31:0] w0_pc, w0_pc4, w0_cnt;
    logic        w0_fe, w0_fl, w0_hl;
    logic [7:0]  w1_pc, w1_pc4, w1_cnt;
    logic        w1_fe, w1_fl, w1_hl;

    pc_fetch_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_step_mode    (step_mode),
        .i_step         (step),
        .i_pc_mux_ctrl  (pc_mux),
        .i_target_addr  (target),
        .i_stall        (stall),
        .i_halt_fetched (halt_f),
        .o_pc           (w0_pc),
        .o_pc_plus4     (w0_pc4),
        .o_fetch_en     (w0_fe),
        .o_flush_ifid   (w0_fl),
        .o_halted       (w0_hl),
        .o_cycle_cnt    (w0_cnt)
    );

    pc_fetch_unit #(
        .NB_PC    (8),
        .RESET_PC (8'hF8),
        .NB_CNT   (8)
    ) dut_w (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_step_mode    (step_mode),
        .i_step         (step),
        .i_pc_mux_ctrl  (pc_mux),
        .i_target_addr  (target[7:0]),
        .i_stall        (stall),
        .i_halt_fetched (halt_f),
        .o_pc           (w1_pc),
        .o_pc_plus4     (w1_pc4),
        .o_fetch_en     (w1_fe),
        .o_flush_ifid   (w1_fl),
        .o_halted       (w1_hl),
        .o_cycle_cnt    (w1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        fe;
        logic        fl;
        logic        hl;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    exp_t  q0[$];
    exp_t  q1[$];
    dchk_t qd[$];

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // Reference model: a started/single-step/granted/halted view of the unit.
    bit          m_go     [2];
    bit          m_single [2];
    bit          m_grant  [2];
    bit          m_halt   [2];
    logic [31:0] m_pc     [2];
    logic [31:0] m_cnt    [2];
    logic [31:0] c_pc_mask  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] c_cnt_mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] c_reset_pc [2] = '{32'h0000_0000, 32'h0000_00F8};

    task automatic tick();
        exp_t e;
        bit   fe;
        for (int d = 0; d < 2; d++) begin
            fe = m_go[d] && !m_halt[d] && (!m_single[d] || m_grant[d]) && !stall && !halt_f;
            e.pc  = m_pc[d];
            e.pc4 = (m_pc[d] + 32'd4) & c_pc_mask[d];
            e.cnt = m_cnt[d];
            e.fe  = fe;
            e.fl  = fe && pc_mux;
            e.hl  = m_halt[d];
            if (!rst) begin
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            if (rst) begin
                m_go[d] = 0; m_single[d] = 0; m_grant[d] = 0; m_halt[d] = 0;
                m_pc[d] = c_reset_pc[d]; m_cnt[d] = 0;
            end else if (m_halt[d]) begin
                m_halt[d] = 1;
            end else if (!m_go[d]) begin
                if (start) begin
                    m_go[d] = 1; m_single[d] = step_mode; m_grant[d] = 0;
                end
            end else begin
                if (halt_f && (!m_single[d] || m_grant[d])) m_halt[d] = 1;
                if (fe) begin
                    m_pc[d]  = (pc_mux ? target : m_pc[d] + 32'd4) & c_pc_mask[d];
                    m_cnt[d] = (m_cnt[d] + 32'd1) & c_cnt_mask[d];
                end
                if (m_single[d]) m_grant[d] = !m_grant[d] && step;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dchk_t c;
        c.name = name; c.act = act; c.exp = exp;
        qd.push_back(c);
    endtask

    task automatic clear_inputs();
        start = 0; step_mode = 0; step = 0; pc_mux = 0;
        target = 0; stall = 0; halt_f = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic start_run(input bit single);
        start = 1; step_mode = single;
        tick();
        start = 0; step_mode = 0;
    endtask

    // Monitor: compares every presented cycle and the directed samples.
    always @(negedge clk) begin
        exp_t  e;
        dchk_t c;
        int    cyc;
        cyc = cyc + 1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks = checks + 1;
            if (w0_pc !== e.pc || w0_pc4 !== e.pc4 || w0_cnt !== e.cnt ||
                w0_fe !== e.fe || w0_fl !== e.fl || w0_hl !== e.hl) begin
                errors = errors + 1;
                $display("FAIL sb32 t=%0t got pc=%h pc4=%h cnt=%0d fe=%b fl=%b hl=%b want pc=%h pc4=%h cnt=%0d fe=%b fl=%b hl=%b",
                         $time, w0_pc, w0_pc4, w0_cnt, w0_fe, w0_fl, w0_hl,
                         e.pc, e.pc4, e.cnt, e.fe, e.fl, e.hl);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks = checks + 1;
            if ({24'h0, w1_pc} !== e.pc || {24'h0, w1_pc4} !== e.pc4 || {24'h0, w1_cnt} !== e.cnt ||
                w1_fe !== e.fe || w1_fl !== e.fl || w1_hl !== e.hl) begin
                errors = errors + 1;
                $display("FAIL sb8 t=%0t got pc=%h pc4=%h cnt=%0d fe=%b fl=%b hl=%b want pc=%h pc4=%h cnt=%0d fe=%b fl=%b hl=%b",
                         $time, w1_pc, w1_pc4, w1_cnt, w1_fe, w1_fl, w1_hl,
                         e.pc[7:0], e.pc4[7:0], e.cnt, e.fe, e.fl, e.hl);
            end
        end
        while (qd.size() > 0) begin
            c = qd.pop_front();
            checks = checks + 1;
            if (c.act !== c.exp) begin
                errors = errors + 1;
                $display("FAIL %s got=%h want=%h", c.name, c.act, c.exp);
            end
        end
        if (cyc > 20000) begin
            errors = errors + 1;
            $display("FAIL timeout got=%0d cycles want<=20000", cyc);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        if (done) begin
            checks = checks + 1;
            if (q0.size() != 0 || q1.size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_go[d] = 0; m_single[d] = 0; m_grant[d] = 0; m_halt[d] = 0;
            m_pc[d] = c_reset_pc[d]; m_cnt[d] = 0;
        end
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        dchk("reset_pc", w0_pc, 32'h0);
        dchk("reset_cnt", w0_cnt, 32'h0);
        dchk("reset_halted", {31'h0, w0_hl}, 32'h0);

        // Continuous run from reset, including 8-bit wrap F8, FC, 00.
        start_run(0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) dchk("wrap_pc8", {24'h0, w1_pc}, 32'h00);
        end
        dchk("run_pc", w0_pc, 32'd20);
        dchk("run_cnt", w0_cnt, 32'd5);

        // Redirect at 0x10.
        do_reset();
        start_run(0);
        repeat (4) tick();
        pc_mux = 1; target = 32'h40;
        #1;
        dchk("redir_flush", {31'h0, w0_fl}, 32'h1);
        tick();
        pc_mux = 0;
        dchk("redir_pc", w0_pc, 32'h40);
        tick();
        dchk("redir_pc_next", w0_pc, 32'h44);

        // Stall blocks a redirect until it drops.
        do_reset();
        start_run(0);
        repeat (8) tick();
        stall = 1; pc_mux = 1; target = 32'h80;
        #1;
        dchk("stall_noflush", {31'h0, w0_fl}, 32'h0);
        tick();
        tick();
        dchk("stall_pc_hold", w0_pc, 32'h20);
        stall = 0;
        #1;
        dchk("stall_release_flush", {31'h0, w0_fl}, 32'h1);
        tick();
        pc_mux = 0;
        dchk("stall_release_pc", w0_pc, 32'h80);

        // Single-step: three pulses, then a pulse consumed by a stall.
        do_reset();
        start_run(1);
        repeat (3) begin
            step = 1; tick();
            step = 0; repeat (3) tick();
        end
        dchk("step_pc", w0_pc, 32'd12);
        dchk("step_cnt", w0_cnt, 32'd3);
        step = 1; tick();
        step = 0; stall = 1; tick();
        stall = 0; tick(); tick();
        dchk("step_stall_pc", w0_pc, 32'd12);
        dchk("step_stall_cnt", w0_cnt, 32'd3);

        // Halt fetched together with a redirect.
        do_reset();
        start_run(0);
        repeat (3) tick();
        halt_f = 1; pc_mux = 1; target = 32'h40;
        #1;
        dchk("halt_noflush", {31'h0, w0_fl}, 32'h0);
        tick();
        halt_f = 0; pc_mux = 0;
        dchk("halt_flag", {31'h0, w0_hl}, 32'h1);
        repeat (10) begin
            start = 1'($urandom); step_mode = 1'($urandom); step = 1'($urandom);
            tick();
        end
        dchk("halt_pc_hold", w0_pc, 32'h0C);
        do_reset();
        dchk("halt_reset_pc", w0_pc, 32'h0);
        dchk("halt_reset_flag", {31'h0, w0_hl}, 32'h0);

        // Reset while a step is executing.
        start_run(1);
        step = 1; tick();
        step = 0; tick(); tick();
        step = 1; tick();
        step = 0; rst = 1; tick();
        rst = 0;
        dchk("rst_exec_pc", w0_pc, 32'h0);
        dchk("rst_exec_cnt", w0_cnt, 32'h0);
        dchk("rst_exec_fe", {31'h0, w0_fe}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            start     = ($urandom_range(0, 3) == 0);
            step_mode = 1'($urandom);
            step      = ($urandom_range(0, 2) == 0);
            pc_mux    = ($urandom_range(0, 3) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            halt_f    = ($urandom_range(0, 40) == 0);
            target    = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        clear_inputs();
        rst = 0;
        tick();
        done = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumes the PC-mux select and branch/jump target produced in ID, and owns the program counter register.
- Sequences instruction fetch under the debug unit's control: continuous run, single-step, or halted.
- Generates the IF/ID flush on taken redirects and counts executed fetch cycles for the debug unit.
- Sits between the ID-stage branch logic, the hazard unit, instruction memory and the debug unit.

Parameters:
NB_PC, 32, program counter width in bits; word-aligned, increment is 4.
RESET_PC, 0, PC value loaded on reset.
NB_CNT, 32, width of the fetch-cycle counter.

Ports:
i_clk  in  1  system clock, rising edge.
i_rst  in  1  synchronous reset, active-high.
i_start  in  1  debug unit: leave IDLE. Level-sampled.
i_step_mode  in  1  sampled with i_start: 1 = single-step, 0 = continuous run.
i_step  in  1  one-cycle pulse; in STEP_WAIT, advances exactly one fetch cycle.
i_pc_mux_ctrl  in  1  1 = take redirect to i_target_addr.
i_target_addr  in  NB_PC  branch/jump target.
i_stall  in  1  hazard unit: hold PC and IF/ID.
i_halt_fetched  in  1  the instruction currently in IF decodes as HALT.
o_pc  out  NB_PC  current fetch address, driven to instruction memory.
o_pc_plus4  out  NB_PC  o_pc + 4, wraps modulo 2^NB_PC.
o_fetch_en  out  1  high in cycles where the PC register updates.
o_flush_ifid  out  1  IF/ID must load a bubble at this edge.
o_halted  out  1  state is HALTED.
o_cycle_cnt  out  NB_CNT  number of cycles with o_fetch_en high since reset.

Behaviour:
- States: IDLE, RUN, STEP_WAIT, STEP_EXEC, HALTED. State register is a clocked flop.
- Reset values:
  - State = IDLE.
  - o_pc = RESET_PC.
  - o_cycle_cnt = 0.
  - o_fetch_en, o_flush_ifid, o_halted = 0.
  - Reset overrides every other input in the same edge, including mid-run and mid-step.
- IDLE:
  - PC held.
  - i_start=1 with i_step_mode=0 -> RUN.
  - i_start=1 with i_step_mode=1 -> STEP_WAIT.
- RUN: o_fetch_en = ~i_stall & ~i_halt_fetched.
- STEP_WAIT:
  - PC held.
  - i_step=1 -> STEP_EXEC.
- STEP_EXEC:
  - Lasts exactly one cycle.
  - o_fetch_en = ~i_stall & ~i_halt_fetched.
  - If i_stall=1 or o_fetch_en=1 -> STEP_WAIT. A stalled step is consumed; the debug unit must issue another pulse.
- Halt:
  - In RUN or STEP_EXEC, i_halt_fetched=1 -> HALTED next edge.
  - The PC is not advanced past the HALT.
  - HALTED is sticky until i_rst; all inputs are ignored and o_halted=1.
- PC update when o_fetch_en=1:
  - PC <= i_target_addr if i_pc_mux_ctrl=1, else PC+4.
  - Wrap-around at 2^NB_PC-4 -> 0 is silent.
- Stall priority: i_stall=1 blocks the redirect. The PC holds, no flush is issued, and the ID logic re-presents the redirect on the next unstalled cycle.
- Flush:
  - o_flush_ifid = o_fetch_en & i_pc_mux_ctrl. Combinational, same cycle as the accepted redirect; no flush latency.
  - If HALT is fetched in the same cycle as a redirect, halt wins: no flush, and the PC does not change.
- o_pc_plus4 is combinational from the PC register.
- o_cycle_cnt increments by 1 on each edge where o_fetch_en=1, and wraps at 2^NB_CNT.
- In IDLE, STEP_WAIT and HALTED: o_fetch_en=0 and o_flush_ifid=0 regardless of i_pc_mux_ctrl.

Test Plan:
- Reset sequence: reset, then i_start=1 with step_mode=0, no stalls, for 5 cycles.
  - Required o_pc sequence: 0, 4, 8, 12, 16, 20.
  - o_cycle_cnt = 5.
  - o_flush_ifid never asserted.
- Redirect: in RUN at PC=0x10, i_pc_mux_ctrl=1 with target=0x40 for one cycle.
  - o_flush_ifid=1 in that cycle.
  - Next o_pc=0x40, then 0x44.
- Stall vs. redirect: at PC=0x20, i_stall=1 and i_pc_mux_ctrl=1 (target 0x80) for 2 cycles, then stall drops with redirect still high.
  - o_pc holds at 0x20 for 2 cycles, with no flush during the stall.
  - Then a flush pulse, and o_pc=0x80.
- Single-step: step_mode=1, start, then 3 i_step pulses spaced 4 cycles apart.
  - o_pc takes 0, 4, 8, 12, changing only on the edge after each pulse.
  - o_cycle_cnt = 3.
  - Additionally, a pulse during i_stall=1 leaves o_pc unchanged and o_cycle_cnt unchanged.
- Halt: i_halt_fetched=1 at PC=0x0C, together with i_pc_mux_ctrl=1.
  - o_halted=1 from the next cycle, with no flush.
  - o_pc stays at 0x0C for 10 cycles despite i_start and i_step activity.
  - i_rst -> o_pc=0, state IDLE, o_halted=0.
- Wrap and reset mid-step:
  - With NB_PC=8, RESET_PC=0xF8 in run mode: o_pc goes 0xF8, 0xFC, 0x00.
  - Reset asserted during STEP_EXEC: o_pc=RESET_PC, o_cycle_cnt=0, o_fetch_en=0 the following cycle.
